mem_line_arbiter: RTL and testbench

- Shares the single-ported backing data memory between the instruction-cache refill path (requester 0, read only) and the data-cache refill/write-back path (requester 1, read or write).
- Each granted request is a whole cache line of LINE_WORDS 32-bit words.
- The block models main-memory latency with a programmable wait, then sequences one memory word per cycle.
- It sits between both caches and the data memory, and drives the memory's write-enable, address, write-data and byte-enable inputs.

---
 rtl/mem_line_arbiter_if.sv | 32 +++
 rtl/mem_line_arbiter.sv | 93 +++++++++
 tb/tb_mem_line_arbiter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_line_arbiter_if.sv
// Cache-side and memory-side bus of the line arbiter.
// slave = arbiter view, master = cache/memory environment view.
interface mem_line_arbiter_if #(parameter int LINE_WORDS = 4);
  logic                       ic_req;
  logic [31:0]                ic_addr;
  logic                       ic_done;
  logic                       dc_req;
  logic                       dc_we;
  logic [31:0]                dc_addr;
  logic [LINE_WORDS*32-1:0]   dc_wline;
  logic                       dc_done;
  logic [LINE_WORDS*32-1:0]   rd_line;
  logic                       busy;
  logic                       grant;
  logic                       mem_we;
  logic [31:0]                mem_addr;
  logic [31:0]                mem_wdata;
  logic [3:0]                 mem_byte_en;
  logic [31:0]                mem_rdata;

  modport slave (
    input  ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wline, mem_rdata,
    output ic_done, dc_done, rd_line, busy, grant,
           mem_we, mem_addr, mem_wdata, mem_byte_en
  );

  modport master (
    output ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wline, mem_rdata,
    input  ic_done, dc_done, rd_line, busy, grant,
           mem_we, mem_addr, mem_wdata, mem_byte_en
  );
endinterface

// File: rtl/mem_line_arbiter.sv
// Shares one memory port between I-cache refills and D-cache refill/write-back,
// moving a whole line per grant after a modelled main-memory latency.
module mem_line_arbiter #(
  parameter int LINE_WORDS  = 4,
  parameter int MEM_LATENCY = 5
) (
  input  logic                clk,
  input  logic                reset,
  mem_line_arbiter_if.slave   bus
);
  localparam int BW = $clog2(LINE_WORDS);
  localparam int WW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [WW-1:0] WAIT_INIT = WW'(MEM_LATENCY - 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_WORDS - 1);
  localparam logic [31:0]   OFF_MASK  = 32'(LINE_WORDS*4 - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_XFER, S_DONE} state_t;

  state_t                       r_state, w_next;
  logic                         r_grant, r_last_grant, r_write;
  logic [31:0]                  r_base;
  logic [LINE_WORDS-1:0][31:0]  r_wline, r_rd_line;
  logic [WW-1:0]                r_wait_cnt;
  logic [BW-1:0]                r_beat;
  logic                         w_accept, w_winner;
  logic [31:0]                  w_addr;

  always_comb begin
    w_accept = bus.ic_req | bus.dc_req;
    // On a tie the requester that did not own the previous line wins.
    w_winner = (bus.ic_req & bus.dc_req) ? ~r_last_grant : bus.dc_req;
    w_addr   = w_winner ? bus.dc_addr : bus.ic_addr;
    w_next   = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_next = S_WAIT;
      S_WAIT:  if (r_wait_cnt == '0) w_next = S_XFER;
      S_XFER:  if (r_beat == LAST_BEAT) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.mem_we      = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_wdata   = '0;
    bus.mem_byte_en = 4'h0;
    if (r_state == S_XFER) begin
      bus.mem_addr    = r_base + {{(30-BW){1'b0}}, r_beat, 2'b00};
      bus.mem_byte_en = 4'hF;
      bus.mem_we      = r_write;
      if (r_write) bus.mem_wdata = r_wline[r_beat];
    end
    bus.ic_done = (r_state == S_DONE) & ~r_grant;
    bus.dc_done = (r_state == S_DONE) &  r_grant;
    bus.busy    = (r_state != S_IDLE);
    bus.grant   = r_grant;
    bus.rd_line = r_rd_line;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b0;
      r_write      <= 1'b0;
      r_base       <= '0;
      r_wline      <= '0;
      r_rd_line    <= '0;
      r_wait_cnt   <= '0;
      r_beat       <= '0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        S_IDLE: if (w_accept) begin
          r_grant      <= w_winner;
          r_last_grant <= w_winner;
          r_base       <= w_addr & ~OFF_MASK;
          r_write      <= w_winner & bus.dc_we;
          if (w_winner & bus.dc_we) r_wline <= bus.dc_wline;
          r_wait_cnt   <= WAIT_INIT;
          r_beat       <= '0;
        end
        S_WAIT: if (r_wait_cnt != '0) r_wait_cnt <= r_wait_cnt - 1'b1;
        S_XFER: begin
          if (!r_write) r_rd_line[r_beat] <= bus.mem_rdata;
          r_beat <= r_beat + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_line_arbiter.sv
// Bench for mem_line_arbiter: cycle-count reference model checked every cycle,
// directed line transactions with literal expectations, then random traffic.
module tb_mem_line_arbiter;
  localparam int W = 4, L = 5, W2 = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_line_arbiter_if #(.LINE_WORDS(W))  bus();
  mem_line_arbiter_if #(.LINE_WORDS(W2)) bus2();

  mem_line_arbiter #(.LINE_WORDS(W),  .MEM_LATENCY(L)) dut  (.clk(clk), .reset(reset), .bus(bus));
  mem_line_arbiter #(.LINE_WORDS(W2), .MEM_LATENCY(1)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];
  assign bus.mem_rdata  = mem[bus.mem_addr[11:2]];
  assign bus2.mem_rdata = bus2.mem_addr ^ 32'h5A5A0000;

  int total = 0, bad = 0;
  bit chk_en = 0;

  // Reference model: position inside the transaction counted in cycles.
  int                   m_cyc;
  logic                 m_grant, m_last, m_write;
  logic [31:0]          m_base;
  logic [W-1:0][31:0]   m_line, m_rd;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic model_step();
    logic        win;
    int          b;
    logic [31:0] a;
    if (reset) begin
      m_cyc = 0; m_grant = 0; m_last = 0; m_write = 0; m_base = 0; m_rd = '0;
    end else if (m_cyc == 0) begin
      if (bus.ic_req || bus.dc_req) begin
        win     = (bus.ic_req && bus.dc_req) ? !m_last : bus.dc_req;
        m_grant = win;
        m_last  = win;
        m_base  = (win ? bus.dc_addr : bus.ic_addr) & ~32'(W*4 - 1);
        m_write = win && bus.dc_we;
        m_line  = bus.dc_wline;
        m_cyc   = 1;
      end
    end else begin
      if (m_cyc > L && m_cyc <= L + W) begin
        b = m_cyc - L - 1;
        a = m_base + 32'(4*b);
        if (m_write) ref_mem[a[11:2]] = m_line[b];
        else         m_rd[b] = ref_mem[a[11:2]];
      end
      m_cyc = (m_cyc == L + W + 1) ? 0 : m_cyc + 1;
    end
  endtask

  task automatic compare_step();
    bit          in_x;
    int          b;
    logic [31:0] ea;
    in_x = (m_cyc > L) && (m_cyc <= L + W);
    b    = in_x ? m_cyc - L - 1 : 0;
    ea   = in_x ? m_base + 32'(4*b) : 32'h0;
    chk("busy",     bus.busy,        m_cyc != 0);
    chk("grant",    bus.grant,       m_grant);
    chk("mem_we",   bus.mem_we,      in_x && m_write);
    chk("mem_addr", bus.mem_addr,    ea);
    chk("wdata",    bus.mem_wdata,   (in_x && m_write) ? m_line[b] : 32'h0);
    chk("byte_en",  bus.mem_byte_en, in_x ? 4'hF : 4'h0);
    chk("ic_done",  bus.ic_done,     m_cyc == L + W + 1 && !m_grant);
    chk("dc_done",  bus.dc_done,     m_cyc == L + W + 1 &&  m_grant);
    chk("rd_line",  bus.rd_line,     m_rd);
  endtask

  task automatic wait_done(input bit dc, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(dc ? bus.dc_done : bus.ic_done) && n < 60);
    chk(dc ? "dc_done_seen" : "ic_done_seen", dc ? bus.dc_done : bus.ic_done, 1'b1);
  endtask

  task automatic ic_agent(input int cnt);
    int n;
    for (int i = 0; i < cnt; i++) begin
      ic_req_drive(1'b1, $urandom);
      wait_done(1'b0, n);
      tick();
      bus.ic_req = 1'b0;
      repeat ($urandom_range(1, 4)) tick();
    end
  endtask

  task automatic ic_req_drive(input bit r, input logic [31:0] a);
    bus.ic_addr = a;
    bus.ic_req  = r;
  endtask

  task automatic dc_agent(input int cnt);
    int n;
    for (int i = 0; i < cnt; i++) begin
      bus.dc_addr  = $urandom;
      bus.dc_we    = 1'($urandom_range(0, 1));
      for (int k = 0; k < W; k++) bus.dc_wline[k*32 +: 32] = $urandom;
      bus.dc_req   = 1'b1;
      wait_done(1'b1, n);
      tick();
      bus.dc_req = 1'b0;
      repeat ($urandom_range(1, 4)) tick();
    end
  endtask

  initial begin
    logic [127:0]          line_a, line_b;
    logic [W2-1:0][31:0]   exp2;
    int n;
    reset = 1'b1;
    bus.ic_req = 0; bus.ic_addr = 0; bus.dc_req = 0; bus.dc_we = 0; bus.dc_addr = 0; bus.dc_wline = '0;
    bus2.ic_req = 0; bus2.ic_addr = 0; bus2.dc_req = 0; bus2.dc_we = 0; bus2.dc_addr = 0; bus2.dc_wline = '0;
    m_cyc = 0; m_grant = 0; m_last = 0; m_write = 0; m_base = 0; m_line = '0; m_rd = '0;
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = 32'(i) * 32'h9E3779B1;
      ref_mem[i] = 32'(i) * 32'h9E3779B1;
    end
    mem[64] = 32'hCAFEBABE; mem[65] = 32'h00000099; mem[66] = 32'h11111111; mem[67] = 32'h22222222;
    ref_mem[64] = 32'hCAFEBABE; ref_mem[65] = 32'h00000099; ref_mem[66] = 32'h11111111; ref_mem[67] = 32'h22222222;
    line_a = {32'h22222222, 32'h11111111, 32'h00000099, 32'hCAFEBABE};
    line_b = {32'h000000A3, 32'h000000A2, 32'h000000A1, 32'h000000A0};

    fork
      forever begin @(posedge clk); model_step(); end
      forever begin
        @(negedge clk);
        if (chk_en) compare_step();
        if (bus.mem_we) mem[bus.mem_addr[11:2]] = bus.mem_wdata;
      end
    join_none

    repeat (2) tick();
    reset  = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_grant", bus.grant, 1'b0);
    chk("rst_rd_line", bus.rd_line, 128'h0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);

    // I-cache line read from an address inside the line
    tick(); ic_req_drive(1'b1, 32'h0000010C);
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      if (c >= 6 && c <= 9) chk("a_addr", bus.mem_addr, 32'h100 + 32'(4*(c-6)));
      if (c == 9) chk("a_early_done", bus.ic_done, 1'b0);
      if (c == 10) chk("a_ic_done", bus.ic_done, 1'b1);
    end
    chk("a_rd_line", bus.rd_line, line_a);
    tick(); bus.ic_req = 1'b0;

    // D-cache write-back
    bus.dc_we = 1'b1; bus.dc_addr = 32'h204; bus.dc_wline = line_b; bus.dc_req = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      if (c >= 6 && c <= 9) begin
        chk("b_we", bus.mem_we, 1'b1);
        chk("b_addr", bus.mem_addr, 32'h200 + 32'(4*(c-6)));
        chk("b_wdata", bus.mem_wdata, 32'hA0 + 32'(c-6));
      end
      if (c == 10) chk("b_dc_done", bus.dc_done, 1'b1);
    end
    chk("b_rd_kept", bus.rd_line, line_a);
    tick(); bus.dc_req = 1'b0; bus.dc_we = 1'b0;
    for (int i = 0; i < 4; i++) chk("b_mem", mem[128+i], 32'hA0 + 32'(i));

    // Tie after reset: D-cache first, then the held I-cache request
    reset = 1'b1; tick(); reset = 1'b0;
    bus.ic_addr = 32'h40; bus.dc_addr = 32'h80; bus.ic_req = 1'b1; bus.dc_req = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("c_grant_dc", bus.grant, 1'b1);
    wait_done(1'b1, n);
    chk("c_dc_lat", n, 9);
    tick(); bus.dc_req = 1'b0;
    wait_done(1'b0, n);
    chk("c_ic_lat", n, 11);
    chk("c_grant_ic", bus.grant, 1'b0);
    tick(); bus.ic_req = 1'b0;

    // Both always requesting: ownership alternates
    reset = 1'b1; tick(); reset = 1'b0;
    bus.ic_req = 1'b1; bus.dc_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!(bus.ic_done || bus.dc_done) && n < 60);
      chk("d_grant", bus.grant, k % 2 == 0);
      chk("d_dc_done", bus.dc_done, k % 2 == 0);
    end
    tick(); bus.ic_req = 1'b0; bus.dc_req = 1'b0;

    // Reset in cycle 7 of a read aborts it
    ic_req_drive(1'b1, 32'h100);
    repeat (7) tick();
    reset = 1'b1; bus.ic_req = 1'b0;
    tick(); reset = 1'b0;
    @(negedge clk);
    chk("e_busy", bus.busy, 1'b0);
    chk("e_rd_line", bus.rd_line, 128'h0);
    chk("e_mem_we", bus.mem_we, 1'b0);
    repeat (12) begin
      @(negedge clk);
      chk("e_no_done", bus.ic_done | bus.dc_done, 1'b0);
    end

    // Short latency, long line instance
    for (int i = 0; i < W2; i++) exp2[i] = (32'h20 + 32'(4*i)) ^ 32'h5A5A0000;
    tick(); bus2.dc_addr = 32'h3C; bus2.dc_req = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      if (c >= 2 && c <= 9) chk("g_addr", bus2.mem_addr, 32'h20 + 32'(4*(c-2)));
      if (c == 9) chk("g_early_done", bus2.dc_done, 1'b0);
      if (c == 10) chk("g_dc_done", bus2.dc_done, 1'b1);
    end
    chk("g_rd_line", bus2.rd_line, exp2);
    tick(); bus2.dc_req = 1'b0;

    // Random contention
    fork
      ic_agent(20);
      dc_agent(20);
    join
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
